// File: rtl/user_edge_accel.sv
// user_edge_accel: OBI edge-detection accelerator for packed 8-bit pixels.
// Latency: 1-cycle OBI response; DATA_IN write to result visible ~7 cycles with an idle FSM.
// Backpressure: always grants; full input FIFO errors the write, full output FIFO stalls the FSM in PUSH.
//
// Ports: clk_i/rst_ni (async active-low), OBI subordinate req_i/gnt_o/addr_i/we_i/be_i/wdata_i/aid_i,
//        rvalid_o/rdata_o/rid_o/err_o; irq_o only when USER_EDGE_ACCEL_IRQ_EN is defined.
// Register map (addr_i[11:2]): 0 CTRL, 1 STATUS, 2 THRESH, 3 DATA_IN, 4 DATA_OUT, 5 EDGE_CNT.
// Optional feature macro: USER_EDGE_ACCEL_IRQ_EN (level irq_o = CTRL.IE & ~OUT_EMPTY, registered).

// user_edge_accel_fifo: generic synchronous FIFO with flush.
// Latency: push visible at the head the cycle after the write edge.
// Backpressure: caller must check full/empty; pushes when full and pops when empty are ignored.
module user_edge_accel_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush,
  input  logic             push_vld,
  input  logic [Width-1:0] push_dat,
  input  logic             pop_rdy,
  output logic [Width-1:0] head_dat,
  output logic             full,
  output logic             empty
);
  localparam int unsigned Aw = (Depth > 1) ? $clog2(Depth) : 1;

  // Extra MSB on each pointer distinguishes full from empty when the indices match.
  logic [Aw:0]      wr_ptr, rd_ptr;
  logic [Width-1:0] mem [Depth];
  logic             do_push, do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[Aw] != rd_ptr[Aw]) && (wr_ptr[Aw-1:0] == rd_ptr[Aw-1:0]);
  assign do_push  = push_vld && !full;
  assign do_pop   = pop_rdy && !empty;
  assign head_dat = mem[rd_ptr[Aw-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush) mem[wr_ptr[Aw-1:0]] <= push_dat;
  end
endmodule

// user_edge_accel: top level, register file + pixel FSM between two FIFOs.
// Latency: OBI response 1 cycle after request; a word takes LOAD + 4 pixel + PUSH states.
// Backpressure: gnt_o tied high; FIFO overflow/underflow reported via err_o, FSM stalls on full output.
module user_edge_accel #(
  parameter int unsigned InDepth  = 4,
  parameter int unsigned OutDepth = 4,
  parameter int unsigned IdWidth  = 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               req_i,
  output logic               gnt_o,
  input  logic [31:0]        addr_i,
  input  logic               we_i,
  input  logic [3:0]         be_i,
  input  logic [31:0]        wdata_i,
  input  logic [IdWidth-1:0] aid_i,
  output logic               rvalid_o,
  output logic [31:0]        rdata_o,
  output logic [IdWidth-1:0] rid_o,
  output logic               err_o
`ifdef USER_EDGE_ACCEL_IRQ_EN
  ,
  output logic               irq_o
`endif
);
  typedef enum logic [2:0] {
    StIdle, StLoad, StPix0, StPix1, StPix2, StPix3, StPush
  } state_t;

  state_t      state_q, state_d;
  logic        ctrl_en;
  logic        ctrl_ie;
  logic [7:0]  thresh_q;
  logic [15:0] edge_cnt;
  logic [31:0] word_q;
  logic [7:0]  prev_q;
  logic        prev_vld;
  logic [3:0]  flags_q, flags_d;

  // Bus-side decode results
  logic        clear, ctrl_wr, thresh_wr, in_push, out_pop, rsp_err_d;
  logic [31:0] rsp_dat_d;

  // FSM-side controls
  logic        in_pop, out_push, pix_active;
  logic [1:0]  pix_idx;
  logic [7:0]  pix_sel;
  logic [8:0]  diff, abs_diff;
  logic        edge_hit;

  // FIFO status
  logic        in_full, in_empty, out_full, out_empty;
  logic [31:0] in_head;
  logic [3:0]  out_head;
  logic        busy;

  logic        unused_ok;
  assign unused_ok = ^{be_i, addr_i[31:12], addr_i[1:0]};

  assign gnt_o = 1'b1;
  assign busy  = (state_q != StIdle);

  user_edge_accel_fifo #(.Width(32), .Depth(InDepth)) u_in_fifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .flush    (clear),
    .push_vld (in_push),
    .push_dat (wdata_i),
    .pop_rdy  (in_pop),
    .head_dat (in_head),
    .full     (in_full),
    .empty    (in_empty)
  );

  user_edge_accel_fifo #(.Width(4), .Depth(OutDepth)) u_out_fifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .flush    (clear),
    .push_vld (out_push),
    .push_dat (flags_q),
    .pop_rdy  (out_pop),
    .head_dat (out_head),
    .full     (out_full),
    .empty    (out_empty)
  );

  // Register decode. FIFO full/empty are the pre-edge values, so a same-cycle
  // FSM pop/push never rescues an overflowing write or underflowing read.
  always_comb begin
    rsp_err_d = 1'b0;
    rsp_dat_d = 32'd0;
    in_push   = 1'b0;
    out_pop   = 1'b0;
    clear     = 1'b0;
    ctrl_wr   = 1'b0;
    thresh_wr = 1'b0;
    if (req_i) begin
      case (addr_i[11:2])
        10'd0: begin
          if (we_i) begin
            ctrl_wr = 1'b1;
            clear   = wdata_i[1];
          end else begin
            rsp_dat_d = {29'd0, ctrl_ie, 1'b0, ctrl_en};
          end
        end
        10'd1: if (!we_i) rsp_dat_d = {28'd0, out_full, out_empty, in_full, busy};
        10'd2: begin
          if (we_i) thresh_wr = 1'b1;
          else      rsp_dat_d = {24'd0, thresh_q};
        end
        10'd3: begin
          if (!we_i || in_full) rsp_err_d = 1'b1;
          else                  in_push   = 1'b1;
        end
        10'd4: begin
          if (we_i || out_empty) begin
            rsp_err_d = 1'b1;
          end else begin
            out_pop   = 1'b1;
            rsp_dat_d = {28'd0, out_head};
          end
        end
        10'd5: if (!we_i) rsp_dat_d = {16'd0, edge_cnt};
        default: rsp_err_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_o <= 1'b0;
      rdata_o  <= 32'd0;
      rid_o    <= '0;
      err_o    <= 1'b0;
    end else begin
      rvalid_o <= req_i;
      rdata_o  <= rsp_dat_d;
      err_o    <= rsp_err_d;
      if (req_i) rid_o <= aid_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl_en  <= 1'b0;
      thresh_q <= 8'd0;
    end else begin
      if (ctrl_wr)   ctrl_en  <= wdata_i[0];
      if (thresh_wr) thresh_q <= wdata_i[7:0];
    end
  end

`ifdef USER_EDGE_ACCEL_IRQ_EN
  logic irq_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl_ie <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      if (ctrl_wr) ctrl_ie <= wdata_i[2];
      irq_q <= ctrl_ie & ~out_empty;
    end
  end
  assign irq_o = irq_q;
`else
  assign ctrl_ie = 1'b0;
`endif

  // Pixel datapath: 9-bit subtraction gives the sign, then fold to magnitude.
  assign diff     = {1'b0, pix_sel} - {1'b0, prev_q};
  assign abs_diff = diff[8] ? (9'd0 - diff) : diff;
  assign edge_hit = prev_vld && (abs_diff > {1'b0, thresh_q});

  always_comb begin
    state_d    = state_q;
    in_pop     = 1'b0;
    out_push   = 1'b0;
    pix_active = 1'b0;
    pix_idx    = 2'd0;
    pix_sel    = 8'd0;
    flags_d    = flags_q;
    case (state_q)
      StIdle: if (ctrl_en && !in_empty) state_d = StLoad;
      StLoad: begin
        in_pop  = 1'b1;
        state_d = StPix0;
      end
      StPix0: begin
        pix_active = 1'b1;
        pix_idx    = 2'd0;
        pix_sel    = word_q[7:0];
        state_d    = StPix1;
      end
      StPix1: begin
        pix_active = 1'b1;
        pix_idx    = 2'd1;
        pix_sel    = word_q[15:8];
        state_d    = StPix2;
      end
      StPix2: begin
        pix_active = 1'b1;
        pix_idx    = 2'd2;
        pix_sel    = word_q[23:16];
        state_d    = StPix3;
      end
      StPix3: begin
        pix_active = 1'b1;
        pix_idx    = 2'd3;
        pix_sel    = word_q[31:24];
        state_d    = StPush;
      end
      StPush: begin
        if (!out_full) begin
          out_push = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (pix_active) flags_d[pix_idx] = edge_hit;
    // CLEAR aborts whatever the FSM is doing this cycle.
    if (clear) begin
      state_d    = StIdle;
      in_pop     = 1'b0;
      out_push   = 1'b0;
      pix_active = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= StIdle;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_q   <= 32'd0;
      flags_q  <= 4'd0;
      prev_q   <= 8'd0;
      prev_vld <= 1'b0;
      edge_cnt <= 16'd0;
    end else if (clear) begin
      prev_vld <= 1'b0;
      edge_cnt <= 16'd0;
    end else begin
      if (in_pop) word_q <= in_head;
      flags_q <= flags_d;
      if (pix_active) begin
        prev_q   <= pix_sel;
        prev_vld <= 1'b1;
        if (edge_hit && (edge_cnt != 16'hFFFF)) edge_cnt <= edge_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_user_edge_accel.sv
// tb_user_edge_accel: directed bench for user_edge_accel.
// Latency: drives one OBI request per task call, samples the response 1 ns after the next rising edge.
// Backpressure: none needed, the DUT always grants.
module tb_user_edge_accel;
  logic        clk;
  logic        rst_n;
  logic        req;
  logic        gnt;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [0:0]  aid;
  logic        rvalid;
  logic [31:0] rdata;
  logic [0:0]  rid;
  logic        err;
`ifdef USER_EDGE_ACCEL_IRQ_EN
  logic        irq;
`endif

  int checks = 0;
  int errors = 0;

  logic        r_vld;
  logic [31:0] r_dat;
  logic [0:0]  r_id;
  logic        r_err;

  localparam logic [31:0] Base = 32'h2000_0000;
  localparam logic [31:0] ACtrl = Base + 32'h00;
  localparam logic [31:0] AStat = Base + 32'h04;
  localparam logic [31:0] AThr  = Base + 32'h08;
  localparam logic [31:0] ADin  = Base + 32'h0C;
  localparam logic [31:0] ADout = Base + 32'h10;
  localparam logic [31:0] ACnt  = Base + 32'h14;

  user_edge_accel #(.InDepth(4), .OutDepth(4), .IdWidth(1)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .req_i    (req),
    .gnt_o    (gnt),
    .addr_i   (addr),
    .we_i     (we),
    .be_i     (be),
    .wdata_i  (wdata),
    .aid_i    (aid),
    .rvalid_o (rvalid),
    .rdata_o  (rdata),
    .rid_o    (rid),
    .err_o    (err)
`ifdef USER_EDGE_ACCEL_IRQ_EN
    ,
    .irq_o    (irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [0:0] id);
    @(negedge clk);
    req   = 1'b1;
    we    = w;
    addr  = a;
    wdata = d;
    aid   = id;
    be    = 4'hF;
    @(posedge clk);
    #1;
    req   = 1'b0;
    we    = 1'b0;
    wdata = 32'd0;
    r_vld = rvalid;
    r_dat = rdata;
    r_id  = rid;
    r_err = err;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus(1'b1, a, d, 1'b0);
  endtask

  task automatic rd(input logic [31:0] a);
    bus(1'b0, a, 32'd0, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 1'b0;
    we    = 1'b0;
    addr  = 32'd0;
    wdata = 32'd0;
    aid   = 1'b0;
    be    = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rvalid", {31'd0, rvalid}, 32'd0);
    check("reset_rdata", rdata, 32'd0);
    check("reset_err", {31'd0, err}, 32'd0);
    check("reset_gnt", {31'd0, gnt}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset STATUS, id echo, idle cycle drops rvalid, bad offset errors
    bus(1'b0, AStat, 32'd0, 1'b1);
    check("status_reset", r_dat, 32'h4);
    check("status_rid", {31'd0, r_id}, 32'd1);
    check("status_err", {31'd0, r_err}, 32'd0);
    check("status_rvalid", {31'd0, r_vld}, 32'd1);
    @(posedge clk); #1;
    check("rvalid_idle", {31'd0, rvalid}, 32'd0);
    rd(Base + 32'h18);
    check("bad_off_err", {31'd0, r_err}, 32'd1);
    check("bad_off_rdata", r_dat, 32'd0);

    // First word: p=00,0A,80,10 thresh 0x20 -> flags 1100, count 2
    wr(AThr, 32'hFFFF_FF20);
    wr(ACtrl, 32'h3);
    check("wr_rdata_zero", r_dat, 32'd0);
    wr(ADin, 32'h1080_0A00);
    check("din_err", {31'd0, r_err}, 32'd0);
    idle(6);
    rd(AStat);
    check("lat_e7_status", r_dat, 32'h5);
    rd(AStat);
    check("lat_e8_status", r_dat, 32'h0);
    rd(ADout);
    check("dout_w0", r_dat, 32'hC);
    check("dout_w0_err", {31'd0, r_err}, 32'd0);
    rd(ACnt);
    check("cnt_w0", r_dat, 32'd2);
    rd(AThr);
    check("thresh_rd", r_dat, 32'h20);
    rd(ACtrl);
    check("ctrl_rd", r_dat, 32'h1);

    // Flat word continuing from prev=0x10
    wr(ADin, 32'h1010_1010);
    idle(8);
    rd(ADout);
    check("dout_flat", r_dat, 32'h0);
    rd(ACnt);
    check("cnt_flat", r_dat, 32'd2);

    // Fill the input FIFO with processing disabled
    wr(ACtrl, 32'h0);
    wr(ADin, 32'hFF00_FF00);
    check("fill0_err", {31'd0, r_err}, 32'd0);
    wr(ADin, 32'hE0E0_E0DF);
    wr(ADin, 32'h0000_00BF);
    wr(ADin, 32'h2100_0021);
    check("fill3_err", {31'd0, r_err}, 32'd0);
    wr(ADin, 32'hFFFF_FFFF);
    check("fill4_overflow_err", {31'd0, r_err}, 32'd1);
    rd(AStat);
    check("status_in_full", r_dat, 32'h6);
    rd(ADin);
    check("din_read_err", {31'd0, r_err}, 32'd1);

    // Drain four words into the output FIFO until it is full
    wr(ACtrl, 32'h1);
    idle(40);
    rd(AStat);
    check("status_out_full", r_dat, 32'h8);
    wr(ADin, 32'h0000_0000);
    idle(10);
    rd(AStat);
    check("status_push_stall", r_dat, 32'h9);
    rd(ADout);
    check("dout_d0", r_dat, 32'hE);
    rd(ADout);
    check("dout_d1_boundary", r_dat, 32'h0);
    rd(ADout);
    check("dout_d2", r_dat, 32'h3);
    rd(ADout);
    check("dout_d3", r_dat, 32'hB);
    rd(ADout);
    check("dout_stalled", r_dat, 32'h1);
    rd(ACnt);
    check("cnt_drain", r_dat, 32'd11);
    rd(AStat);
    check("status_drained", r_dat, 32'h4);
    wr(ADout, 32'h0);
    check("dout_write_err", {31'd0, r_err}, 32'd1);

    // CLEAR while the FSM is mid-word
    wr(ADin, 32'h1234_5678);
    idle(2);
    rd(AStat);
    check("status_busy", r_dat, 32'h5);
    wr(ACtrl, 32'h3);
    rd(AStat);
    check("status_after_clear", r_dat, 32'h4);
    rd(ACnt);
    check("cnt_after_clear", r_dat, 32'd0);
    rd(ADout);
    check("dout_empty_err", {31'd0, r_err}, 32'd1);
    check("dout_empty_rdata", r_dat, 32'd0);
    idle(10);
    rd(AStat);
    check("status_discarded", r_dat, 32'h4);

    // Asynchronous reset during PIX2
    wr(ADin, 32'h0102_0304);
    idle(3);
    bus(1'b0, AThr, 32'd0, 1'b1);
    check("pre_rst_thresh", r_dat, 32'h20);
    rst_n = 1'b0;
    #1;
    check("arst_rvalid", {31'd0, rvalid}, 32'd0);
    check("arst_rdata", rdata, 32'd0);
    check("arst_rid", {31'd0, rid}, 32'd0);
    check("arst_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rd(AStat);
    check("post_rst_status", r_dat, 32'h4);
    rd(AThr);
    check("post_rst_thresh", r_dat, 32'd0);
    rd(ACtrl);
    check("post_rst_ctrl", r_dat, 32'd0);
    rd(ACnt);
    check("post_rst_cnt", r_dat, 32'd0);

    // Count saturation is not reachable in budget; exercise the first-pixel rule instead
    wr(ACtrl, 32'h1);
    wr(ADin, 32'h00FF_00FF);
    idle(8);
    rd(ADout);
    check("first_pixel_no_edge", r_dat, 32'hE);

`ifdef USER_EDGE_ACCEL_IRQ_EN
    wr(ACtrl, 32'h5);
    rd(ACtrl);
    check("ctrl_ie_rd", r_dat, 32'h5);
    @(posedge clk); #1;
    check("irq_idle", {31'd0, irq}, 32'd0);
    wr(ADin, 32'h0000_0000);
    idle(10);
    check("irq_set", {31'd0, irq}, 32'd1);
    rd(ADout);
    check("irq_hold", {31'd0, irq}, 32'd1);
    @(posedge clk); #1;
    check("irq_clear", {31'd0, irq}, 32'd0);
`else
    wr(ACtrl, 32'h5);
    rd(ACtrl);
    check("ctrl_ie_masked", r_dat, 32'h1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
